// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the RV32 fetch path
package cpu_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble only kills the instruction; the pc field is left as-is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.pc    <= '0;
      q.inst  <= BUBBLE_INST;
      q.valid <= 1'b0;
    end else if (bubble) begin
      q.inst  <= BUBBLE_INST;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction fetch: PC, single-outstanding fetch FSM, IF/ID load
module fetch_stage #(
  parameter int               XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_ready,
  input  logic            im_rvalid,
  input  logic [31:0]     im_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_valid
);

  cpu_pkg::fetch_state_e state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic [31:0]     inst_buf;
  logic            buf_load;
  logic            deliver;
  logic [31:0]     deliver_inst;
  logic            advance;
  cpu_pkg::if_id_t if_id_d, if_id_q;

  assign advance = pc_write & if_id_write;
  assign im_req  = (state == cpu_pkg::S_REQ);
  assign im_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= cpu_pkg::S_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      inst_buf <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      if (buf_load) inst_buf <= im_rdata;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drop_n       = drop;
    buf_load     = 1'b0;
    deliver      = 1'b0;
    deliver_inst = im_rdata;
    case (state)
      cpu_pkg::S_REQ: begin
        if (im_ready) state_n = cpu_pkg::S_WAIT;
      end
      cpu_pkg::S_WAIT: begin
        if (im_rvalid) begin
          state_n = cpu_pkg::S_REQ;
          if (drop) begin
            drop_n = 1'b0;
          end else if (advance) begin
            deliver = 1'b1;
            pc_n    = pc + XLEN'(4);
          end else begin
            buf_load = 1'b1;
            state_n  = cpu_pkg::S_HOLD;
          end
        end
      end
      cpu_pkg::S_HOLD: begin
        deliver_inst = inst_buf;
        if (advance) begin
          deliver = 1'b1;
          pc_n    = pc + XLEN'(4);
          state_n = cpu_pkg::S_REQ;
        end
      end
      default: state_n = cpu_pkg::S_REQ;
    endcase

    // Redirect overrides everything; an outstanding request must have its response dropped.
    if (redirect) begin
      pc_n     = redirect_pc;
      deliver  = 1'b0;
      buf_load = 1'b0;
      case (state)
        cpu_pkg::S_REQ: begin
          state_n = im_ready ? cpu_pkg::S_WAIT : cpu_pkg::S_REQ;
          drop_n  = im_ready;
        end
        cpu_pkg::S_WAIT: begin
          state_n = im_rvalid ? cpu_pkg::S_REQ : cpu_pkg::S_WAIT;
          drop_n  = ~im_rvalid;
        end
        default: begin
          state_n = cpu_pkg::S_REQ;
          drop_n  = 1'b0;
        end
      endcase
    end
  end

  assign if_id_d.pc    = pc;
  assign if_id_d.inst  = deliver_inst;
  assign if_id_d.valid = 1'b1;

  if_id_reg #(
    .BUBBLE_INST (NOP_INST)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (deliver),
    .bubble (redirect | (~deliver & if_id_write)),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign if_id_pc    = if_id_q.pc;
  assign if_id_inst  = if_id_q.inst;
  assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, if_id_write, redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready, im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] if_id_pc, if_id_inst;
  logic        if_id_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ready    (im_ready),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
  );

  typedef struct {
    logic        pw, wr, rd;
    logic [31:0] rpc;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pw, input logic wr, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.pw = pw; v.wr = wr; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pw, input logic wr, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rv, input logic [31:0] rdata);
    pc_write = pw; if_id_write = wr; redirect = rd; redirect_pc = rpc;
    im_ready = rdy; im_rvalid = rv; im_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, 0, 0, 0, 0, 0);
    // pw wr rd rpc  rdy rv rdata | req addr | valid pc inst
    add(1,1,0,0,          1,0,0,            1,32'h000,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00A0_0093,0,32'h000,      1,32'h000,32'h00A0_0093);
    add(1,1,0,0,          1,0,0,            1,32'h004,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00A1_0093,0,32'h004,      1,32'h004,32'h00A1_0093);
    add(1,1,0,0,          1,0,0,            1,32'h008,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00A2_0093,0,32'h008,      1,32'h008,32'h00A2_0093);
    add(1,1,0,0,          1,0,0,            1,32'h00C,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00A3_0093,0,32'h00C,      1,32'h00C,32'h00A3_0093);
    // stall around the response at pc 0x10
    add(1,0,0,0,          1,0,0,            1,32'h010,      1,32'h00C,32'h00A3_0093);
    add(1,0,0,0,          0,1,32'h00B0_0093,0,32'h010,      1,32'h00C,32'h00A3_0093);
    add(1,0,0,0,          0,0,0,            0,32'h010,      1,32'h00C,32'h00A3_0093);
    add(1,0,0,0,          0,0,0,            0,32'h010,      1,32'h00C,32'h00A3_0093);
    add(0,1,0,0,          0,0,0,            0,32'h010,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h0000_0BAD,0,32'h010,      1,32'h010,32'h00B0_0093);
    // redirect while waiting, late response dropped
    add(1,1,0,0,          1,0,0,            1,32'h014,      0,0,NOP);
    add(1,1,1,32'h200,    0,0,0,            0,32'h014,      0,0,NOP);
    add(1,1,0,0,          0,0,0,            0,32'h200,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h0000_DEAD,0,32'h200,      0,0,NOP);
    add(1,1,0,0,          1,0,0,            1,32'h200,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00C0_0093,0,32'h200,      1,32'h200,32'h00C0_0093);
    // redirect coincident with response, if_id_write low
    add(1,1,0,0,          1,0,0,            1,32'h204,      0,0,NOP);
    add(1,0,1,32'h300,    0,1,32'h0000_0BAD,0,32'h204,      0,0,NOP);
    // memory not ready for four cycles
    for (int k = 0; k < 4; k++)
      add(1,1,0,0,        0,0,0,            1,32'h300,      0,0,NOP);
    add(1,1,0,0,          1,0,0,            1,32'h300,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00D0_0093,0,32'h300,      1,32'h300,32'h00D0_0093);
    // pc wrap
    add(1,1,1,32'hFFFF_FFFC,0,0,0,          1,32'h304,      0,0,NOP);
    add(1,1,0,0,          1,0,0,            1,32'hFFFF_FFFC,0,0,NOP);
    add(1,1,0,0,          0,1,32'h00E0_0093,0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'h00E0_0093);
    add(1,1,0,0,          0,0,0,            1,32'h000,      0,0,NOP);
    // redirect on the accept cycle
    add(1,1,1,32'h400,    1,0,0,            1,32'h000,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h0000_0BAD,0,32'h400,      0,0,NOP);
    add(1,1,0,0,          1,0,0,            1,32'h400,      0,0,NOP);
    add(1,1,0,0,          0,1,32'h00F2_0093,0,32'h400,      1,32'h400,32'h00F2_0093);

    tick();
    tick();
    chk("rst_req",   im_req,      1);
    chk("rst_addr",  im_addr,     0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_inst",  if_id_inst,  NOP);
    chk("rst_pc",    if_id_pc,    0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pw, vecs[i].wr, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rv, vecs[i].rdata);
      chk($sformatf("v%0d_req", i),  im_req,  vecs[i].e_req);
      chk($sformatf("v%0d_addr", i), im_addr, vecs[i].e_addr);
      tick();
      chk($sformatf("v%0d_valid", i), if_id_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_inst", i),  if_id_inst,  vecs[i].e_inst);
      if (vecs[i].e_valid) chk($sformatf("v%0d_pc", i), if_id_pc, vecs[i].e_pc);
    end

    // reset while a fetch is outstanding, stale response afterwards
    drive(1, 1, 0, 0, 1, 0, 0);
    tick();
    chk("mid_wait_req", im_req, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_req",   im_req,      1);
    chk("mid_rst_addr",  im_addr,     0);
    chk("mid_rst_valid", if_id_valid, 0);
    tick();
    rst = 1'b1;
    drive(1, 1, 0, 0, 0, 1, 32'h0000_0BAD);
    chk("stale_req",  im_req,  1);
    chk("stale_addr", im_addr, 0);
    tick();
    chk("stale_valid", if_id_valid, 0);
    chk("stale_req2",  im_req,      1);
    drive(1, 1, 0, 0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 1, 32'h00F0_0093);
    tick();
    chk("post_rst_valid", if_id_valid, 1);
    chk("post_rst_pc",    if_id_pc,    0);
    chk("post_rst_inst",  if_id_inst,  32'h00F0_0093);
    chk("post_rst_addr",  im_addr,     4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
